// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port data memory.
// Port 0 is the core load/store path, port 1 the loader/debug path.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Req0,
    input  logic                  We0,
    input  logic [ADDR_WIDTH-1:0] Addr0,
    input  logic [DATA_WIDTH-1:0] WData0,
    input  logic                  Req1,
    input  logic                  We1,
    input  logic [ADDR_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0] WData1,
    output logic                  Gnt0,
    output logic                  Gnt1,
    output logic                  RValid0,
    output logic                  RValid1,
    output logic [DATA_WIDTH-1:0] RData0,
    output logic [DATA_WIDTH-1:0] RData1,
    output logic                  MemWE,
    output logic [ADDR_WIDTH-1:0] MemA,
    output logic [DATA_WIDTH-1:0] MemWD,
    input  logic [DATA_WIDTH-1:0] MemRD
);

    logic                  last;
    logic                  gnt;
    logic                  gnt_src;
    logic                  iss_v;
    logic                  iss_src;
    logic                  iss_we;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic [DATA_WIDTH-1:0] iss_wdata;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        Gnt0    = rst_n & Req0 & (~Req1 | last);
        Gnt1    = rst_n & Req1 & (~Req0 | ~last);
        gnt     = Gnt0 | Gnt1;
        gnt_src = Gnt1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= 1'b1;
            iss_v     <= 1'b0;
            iss_src   <= 1'b0;
            iss_we    <= 1'b0;
            iss_addr  <= '0;
            iss_wdata <= '0;
        end else begin
            iss_v <= gnt;
            if (gnt) begin
                last      <= gnt_src;
                iss_src   <= gnt_src;
                iss_we    <= gnt_src ? We1 : We0;
                iss_addr  <= gnt_src ? Addr1 : Addr0;
                iss_wdata <= gnt_src ? WData1 : WData0;
            end
        end
    end

    assign MemWE = iss_v & iss_we;
    assign MemA  = iss_addr;
    assign MemWD = iss_wdata;

    // Read data is captured per port; the idle port keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RValid0 <= 1'b0;
            RValid1 <= 1'b0;
            RData0  <= '0;
            RData1  <= '0;
        end else begin
            RValid0 <= iss_v & ~iss_we & ~iss_src;
            RValid1 <= iss_v & ~iss_we & iss_src;
            if (iss_v && !iss_we) begin
                if (iss_src)
                    RData1 <= MemRD;
                else
                    RData0 <= MemRD;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-queue model checked every cycle,
// plus directed vectors with literal expectations.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Req0 = 0, We0 = 0, Req1 = 0, We1 = 0;
    logic [7:0]  Addr0 = 0, Addr1 = 0;
    logic [31:0] WData0 = 0, WData1 = 0;
    logic        Gnt0, Gnt1, RValid0, RValid1, MemWE;
    logic [31:0] RData0, RData1, MemWD, MemRD;
    logic [7:0]  MemA;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    int nvec = 0;
    int nmis = 0;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .WData0(WData0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .WData1(WData1),
        .Gnt0(Gnt0), .Gnt1(Gnt1),
        .RValid0(RValid0), .RValid1(RValid1),
        .RData0(RData0), .RData1(RData1),
        .MemWE(MemWE), .MemA(MemA), .MemWD(MemWD), .MemRD(MemRD)
    );

    always #5 clk = ~clk;

    assign MemRD = mem[MemA];
    always @(posedge clk) if (MemWE) mem[MemA] <= MemWD;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          g;
        bit          p;
        bit          we;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] rd;
    } txn_t;

    txn_t        q[$];
    txn_t        t;
    int          cyc = 0;
    bit          m_last = 1'b1;
    logic [31:0] e_rd0 = 0, e_rd1 = 0;
    bit          e_rv0, e_rv1, has_g, gp;
    int          ii, ri;

    // Model: grant by rule, each grant becomes a transaction that shows
    // on the memory pins one cycle later and as a response two cycles later.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            m_last = 1'b1;
            e_rd0 = 0;
            e_rd1 = 0;
            chk("rst_gnt0", Gnt0, 0);
            chk("rst_gnt1", Gnt1, 0);
            chk("rst_memwe", MemWE, 0);
            chk("rst_mema", MemA, 0);
            chk("rst_memwd", MemWD, 0);
            chk("rst_rvalid0", RValid0, 0);
            chk("rst_rvalid1", RValid1, 0);
            chk("rst_rdata0", RData0, 0);
            chk("rst_rdata1", RData1, 0);
        end else begin
            has_g = Req0 || Req1;
            if (Req0 && Req1) gp = !m_last;
            else gp = Req1;
            chk("gnt0", Gnt0, has_g && !gp);
            chk("gnt1", Gnt1, has_g && gp);

            ii = -1;
            ri = -1;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].g == cyc - 1) ii = i;
                if (q[i].g == cyc - 2) ri = i;
            end

            if (ii >= 0) begin
                chk("memwe", MemWE, q[ii].we);
                chk("mema", MemA, q[ii].a);
                if (q[ii].we) chk("memwd", MemWD, q[ii].d);
                else q[ii].rd = ref_mem[q[ii].a];
            end else begin
                chk("memwe_idle", MemWE, 0);
            end

            e_rv0 = 0;
            e_rv1 = 0;
            if (ri >= 0 && !q[ri].we) begin
                if (q[ri].p) begin
                    e_rv1 = 1;
                    e_rd1 = q[ri].rd;
                end else begin
                    e_rv0 = 1;
                    e_rd0 = q[ri].rd;
                end
            end
            chk("rvalid0", RValid0, e_rv0);
            chk("rvalid1", RValid1, e_rv1);
            chk("rdata0", RData0, e_rd0);
            chk("rdata1", RData1, e_rd1);

            if (ii >= 0 && q[ii].we) ref_mem[q[ii].a] = q[ii].d;

            while (q.size() > 0 && q[0].g <= cyc - 2) void'(q.pop_front());
            if (has_g) begin
                t.g  = cyc;
                t.p  = gp;
                t.we = gp ? We1 : We0;
                t.a  = gp ? Addr1 : Addr0;
                t.d  = gp ? WData1 : WData0;
                t.rd = 0;
                q.push_back(t);
                m_last = gp;
            end
        end
    end

    task automatic step(input bit r0, input bit w0, input logic [7:0] a0,
                        input logic [31:0] d0, input bit r1, input bit w1,
                        input logic [7:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        Req0 = r0; We0 = w0; Addr0 = a0; WData0 = d0;
        Req1 = r1; We1 = w1; Addr1 = a1; WData1 = d1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[8'h01] = 32'hA;          ref_mem[8'h01] = 32'hA;
        mem[8'h02] = 32'hB;          ref_mem[8'h02] = 32'hB;
        mem[8'h10] = 32'hDEADBEEF;   ref_mem[8'h10] = 32'hDEADBEEF;
        mem[8'h40] = 32'h11111111;   ref_mem[8'h40] = 32'h11111111;

        idle(2);
        step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        rst_n = 1'b1;
        // Tie straight after reset: order 0,1,0,1
        at_neg; chk("tie_n_gnt0", Gnt0, 1);
        step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        at_neg; chk("tie_n1_gnt1", Gnt1, 1);
        step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        at_neg; chk("tie_n2_gnt0", Gnt0, 1);
        chk("tie_n2_rv0", RValid0, 1);
        chk("tie_n2_rd0", RData0, 32'hA);
        step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        at_neg; chk("tie_n3_gnt1", Gnt1, 1);
        chk("tie_n3_rv1", RValid1, 1);
        chk("tie_n3_rd1", RData1, 32'hB);

        // Idle keeps the pointer: next tie still goes to port 0
        idle(10);
        step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        at_neg; chk("idle_tie_gnt0", Gnt0, 1);
        step(0, 0, 0, 0, 1, 0, 8'h02, 0);
        at_neg; chk("idle_tie_gnt1", Gnt1, 1);
        idle(3);

        // Single read
        step(1, 0, 8'h10, 0, 0, 0, 0, 0);
        at_neg; chk("rd_n_gnt0", Gnt0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        at_neg; chk("rd_n1_mema", MemA, 8'h10);
        chk("rd_n1_memwe", MemWE, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        at_neg; chk("rd_n2_rv0", RValid0, 1);
        chk("rd_n2_rd0", RData0, 32'hDEADBEEF);
        chk("rd_n2_rv1", RValid1, 0);
        idle(2);

        // Write then read, same port
        step(1, 1, 8'h20, 32'h12345678, 0, 0, 0, 0);
        step(1, 0, 8'h20, 0, 0, 0, 0, 0);
        at_neg; chk("wr_n1_memwe", MemWE, 1);
        chk("wr_n1_memwd", MemWD, 32'h12345678);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        at_neg; chk("wr_n2_memwe", MemWE, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        at_neg; chk("wr_n3_rv0", RValid0, 1);
        chk("wr_n3_rd0", RData0, 32'h12345678);
        idle(2);

        // Cross-port read-after-write
        step(0, 0, 0, 0, 1, 1, 8'h30, 32'hCAFE0001);
        step(1, 0, 8'h30, 0, 0, 0, 0, 0);
        idle(2);
        at_neg; chk("raw_n3_rv0", RValid0, 1);
        chk("raw_n3_rd0", RData0, 32'hCAFE0001);
        idle(2);

        // Reset in the middle of a write
        step(1, 1, 8'h40, 32'h55, 0, 0, 0, 0);
        at_neg; chk("mrst_n_gnt0", Gnt0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1 chk("mrst_memwe", MemWE, 0);
        chk("mrst_mema", MemA, 0);
        chk("mrst_memwd", MemWD, 0);
        step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        rst_n = 1'b1;
        at_neg; chk("mrst_first_gnt0", Gnt0, 1);
        chk("mrst_first_gnt1", Gnt1, 0);
        chk("mrst_mem40", mem[8'h40], 32'h11111111);
        step(1, 0, 8'h01, 0, 1, 0, 8'h02, 0);
        at_neg; chk("mrst_second_gnt1", Gnt1, 1);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-port data memory. It shares the memory between the core load/store path (port 0) and the loader/debug path (port 1), using round-robin arbitration. Accepted requests pass through a registered issue stage that drives the memory's WE/A/WD pins, and read data returns through a registered response stage. It sits between the requesters and the data memory instance, replacing the direct ALUResult/MemWrite/WriteData hookup.

## Interface
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 8, memory address width (matches data memory A[7:0]).

- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Req0 / Req1  input  1  request valid, held with fields until granted.
- We0 / We1  input  1  1 = write, 0 = read.
- Addr0 / Addr1  input  ADDR_WIDTH  request address.
- WData0 / WData1  input  DATA_WIDTH  write data.
- Gnt0 / Gnt1  output  1  request accepted this cycle (combinational).
- RValid0 / RValid1  output  1  one-cycle read-data-valid strobe.
- RData0 / RData1  output  DATA_WIDTH  read data, meaningful when RValidx=1.
- MemWE  output  1  memory write enable.
- MemA  output  ADDR_WIDTH  memory address.
- MemWD  output  DATA_WIDTH  memory write data.
- MemRD  input  DATA_WIDTH  memory read data (combinational from MemA).

## Operation
- Arbitration is combinational each cycle from Req0, Req1 and the 1-bit pointer Last.
  - Only one request asserted: that port is granted.
  - Both asserted: the port != Last is granted.
  - Neither asserted: no grant.
- At most one of Gnt0/Gnt1 is high in any cycle. Gnt is forced 0 while rst_n=0.
- On any grant, Last <= granted index at the clock edge. Last resets to 1, so port 0 wins the first tie.
- Issue stage registers, loaded on grant:
  - IssV <= 1, IssSrc <= port, IssWe, IssAddr, IssWData.
  - With no grant, IssV <= 0.
- Memory drive, from the issue stage:
  - MemWE = IssV & IssWe.
  - MemA = IssAddr and MemWD = IssWData, held from the registers.
  - MemWE must be 0 whenever IssV=0.
- Response stage: when IssV & ~IssWe, RDataR <= MemRD and RValid[IssSrc] <= 1 on the next edge. Otherwise RValid0/1 <= 0.
  - RDatax holds its last captured value; the other port's RData is unchanged.
- Writes produce no response. Gnt is the only acknowledgement.
- Requests complete in grant order. This gives a global memory order across both ports.
- No backpressure on responses: requesters must accept RValid in the cycle it is asserted.

## Timing
- Cycle N: Req high and Gnt high (same cycle).
- Cycle N+1: MemWE/MemA/MemWD driven. A write commits at the end of N+1.
- Cycle N+2: for a read, RValidx=1 and RDatax is valid.
- Read latency is 2 cycles from grant. Throughput is one access per cycle, back-to-back, with no bubbles.
- Read-after-write, same address, granted at N then N+1 (either ports): the read returns the new data at N+3.
- Continuous contention: grants alternate 0,1,0,1… each port gets 50%. A port with Req held waits at most 1 cycle.
- Reset values, asynchronous on rst_n=0:
  - Outputs: MemWE=0, MemA=0, MemWD=0, RValid0/1=0, RData0/1=0, Gnt0/1=0.
  - Internal state: IssV=0, Last=1.
- Reset mid-operation: in-flight issue and response stages are discarded. A pending write is not performed (MemWE drops immediately) and no RValid is produced.
- After rst_n deasserts, the first grant can occur in the first cycle with Req high.

## Test plan
- Single read: preload mem[0x10]=0xDEADBEEF. Assert Req0, We0=0, Addr0=0x10 at N. Required: Gnt0=1 at N; MemA=0x10, MemWE=0 at N+1; RValid0=1 and RData0=0xDEADBEEF at N+2; RValid1=0 throughout.
- Write then read, same port: Req0 write 0x20←0x12345678 at N, then read 0x20 at N+1. Required: MemWE=1 only at N+1; RValid0=1 with 0x12345678 at N+3.
- Tie after reset: Req0 and Req1 both held as reads of 0x01/0x02 (contents 0xA, 0xB) for 4 cycles. Required:
  - grant order 0,1,0,1;
  - RValid0 with 0xA at N+2, RValid1 with 0xB at N+3;
  - never both Gnt high.
- Cross-port RAW: port 1 writes 0x30←0xCAFE0001 at N, port 0 reads 0x30 at N+1. Required: RData0=0xCAFE0001 at N+3.
- Reset mid-write: grant a write of 0x40←0x55 at N, drop rst_n during N+1 before the edge. Required:
  - MemWE=0 immediately and all outputs at reset values;
  - mem[0x40] unchanged;
  - after release with Req0/Req1 tied, port 0 granted first.
- Idle: no Req for 10 cycles. Required: MemWE=0, RValid0/1=0, and Last unchanged.
